// File: rtl/dibit_symbol_serializer_pkg.sv
// Shared types and helpers for the dibit symbol serializer feeding the
// 2-input Moore FSM stage.
package dibit_symbol_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_e;

  // 2'b10 steers the downstream FSM back to its initial state A.
  localparam logic [1:0] IDLE_SYM_DEF = 2'b10;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/dibit_symbol_serializer.sv
// Serializes DATA_WIDTH-bit messages into 2-bit symbols, MSB dibit first,
// with a one-entry pending buffer and optional idle gap between messages.
module dibit_symbol_serializer
  import dibit_symbol_serializer_pkg::*;
#(
  parameter int         DATA_WIDTH = 8,
  parameter int         GAP_SYMS   = 0,
  parameter logic [1:0] IDLE_SYM   = IDLE_SYM_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_val,
  output logic                  in_rdy,
  input  logic [DATA_WIDTH-1:0] in_msg,
  output logic [1:0]            out_sym,
  output logic                  out_val,
  output logic                  out_last
);

  localparam int            N        = DATA_WIDTH / 2;
  localparam int            RW       = clog2(N);
  localparam logic [RW-1:0] REM_LOAD = RW'(N - 1);
  localparam logic [3:0]    GAP_LOAD = 4'(GAP_SYMS - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [RW-1:0]         rem_q, rem_d;
  logic [3:0]            gap_q, gap_d;
  logic [DATA_WIDTH-1:0] pbuf_q, pbuf_d;
  logic                  pbuf_val_q, pbuf_val_d;
  logic [1:0]            sym_q, sym_d;
  logic                  val_q, val_d;
  logic                  last_q, last_d;

  logic                  accept;
  logic                  load_pbuf;
  logic                  load_in;
  logic [DATA_WIDTH-1:0] load_src;

  assign in_rdy   = !pbuf_val_q;
  assign accept   = in_val && in_rdy;
  assign out_sym  = sym_q;
  assign out_val  = val_q;
  assign out_last = last_q;

  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    rem_d      = rem_q;
    gap_d      = gap_q;
    pbuf_d     = pbuf_q;
    pbuf_val_d = pbuf_val_q;
    sym_d      = sym_q;
    val_d      = val_q;
    last_d     = last_q;
    load_pbuf  = 1'b0;
    load_in    = 1'b0;
    load_src   = in_msg;

    unique case (state_q)
      SHIFT: begin
        if (rem_q != '0) begin
          sym_d  = sreg_q[DATA_WIDTH-1 -: 2];
          sreg_d = sreg_q << 2;
          rem_d  = rem_q - RW'(1);
          val_d  = 1'b1;
          last_d = (rem_q == RW'(1));
        end else if (GAP_SYMS > 0) begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
          sym_d   = IDLE_SYM;
          val_d   = 1'b0;
          last_d  = 1'b0;
        end else begin
          load_pbuf = pbuf_val_q;
          load_in   = !pbuf_val_q && accept;
        end
      end
      GAP: begin
        if (gap_q != 4'd0) begin
          gap_d = gap_q - 4'd1;
        end else begin
          load_pbuf = pbuf_val_q;
          load_in   = !pbuf_val_q && accept;
        end
      end
      default: begin
        load_pbuf = pbuf_val_q;
        load_in   = !pbuf_val_q && accept;
      end
    endcase

    // Any message-boundary decision that finds nothing to send falls to IDLE.
    if ((state_q == IDLE) || (state_q == GAP && gap_q == 4'd0) ||
        (state_q == SHIFT && rem_q == '0 && GAP_SYMS == 0)) begin
      state_d = IDLE;
      sym_d   = IDLE_SYM;
      val_d   = 1'b0;
      last_d  = 1'b0;
    end

    if (load_pbuf || load_in) begin
      load_src = load_pbuf ? pbuf_q : in_msg;
      state_d  = SHIFT;
      sym_d    = load_src[DATA_WIDTH-1 -: 2];
      sreg_d   = load_src << 2;
      rem_d    = REM_LOAD;
      val_d    = 1'b1;
      last_d   = 1'b0;
    end

    // A drain and a fresh accept on the same edge leave the buffer full.
    if (load_pbuf) pbuf_val_d = 1'b0;
    if (accept && !load_in) begin
      pbuf_d     = in_msg;
      pbuf_val_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      gap_q      <= 4'd0;
      pbuf_val_q <= 1'b0;
      sym_q      <= IDLE_SYM;
      val_q      <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      gap_q      <= gap_d;
      pbuf_val_q <= pbuf_val_d;
      sym_q      <= sym_d;
      val_q      <= val_d;
      last_q     <= last_d;
    end
  end

  // NOTE: data registers are not reset; they are only read behind a valid
  // flag or a SHIFT state that reset already clears.
  always_ff @(posedge clk) begin
    sreg_q <= sreg_d;
    pbuf_q <= pbuf_d;
  end

endmodule

// File: tb/tb_dibit_symbol_serializer.sv
// Bench for dibit_symbol_serializer: cycle tables, gap and reset corner
// sequences, and a randomized run against an expected-dibit scoreboard.
module tb_dibit_symbol_serializer;

  localparam int W = 8;
  localparam int N = W / 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         val0 = 1'b0, val2 = 1'b0;
  logic [W-1:0] msg0 = '0, msg2 = '0;
  logic         rdy0, rdy2, ov0, ov2, ol0, ol2;
  logic [1:0]   sym0, sym2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dibit_symbol_serializer #(.DATA_WIDTH(W), .GAP_SYMS(0)) dut0 (
    .clk(clk), .reset(reset), .in_val(val0), .in_rdy(rdy0), .in_msg(msg0),
    .out_sym(sym0), .out_val(ov0), .out_last(ol0)
  );

  dibit_symbol_serializer #(.DATA_WIDTH(W), .GAP_SYMS(2)) dut2 (
    .clk(clk), .reset(reset), .in_val(val2), .in_rdy(rdy2), .in_msg(msg2),
    .out_sym(sym2), .out_val(ov2), .out_last(ol2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard model ----------------
  typedef struct { logic [1:0] sym; logic last; } exp_t;
  exp_t q [2][$];
  int   idle_cnt [2];
  bit   mid [2];
  bit   sb_en = 1'b0;

  task automatic sb_step(input int id, input int gap, input logic [1:0] sym,
                         input logic ov, input logic ol, input logic v,
                         input logic rdy, input logic [W-1:0] msg);
    exp_t e;
    if (ov) begin
      if (q[id].size() == 0) begin
        check($sformatf("sb%0d_unexpected_dibit", id), 1, 0);
      end else begin
        e = q[id].pop_front();
        if (!mid[id] && gap > 0)
          check($sformatf("sb%0d_gap_len", id), idle_cnt[id] >= gap, 1);
        check($sformatf("sb%0d_sym", id), sym, e.sym);
        check($sformatf("sb%0d_last", id), ol, e.last);
        mid[id] = !e.last;
      end
      idle_cnt[id] = 0;
    end else begin
      check($sformatf("sb%0d_idle_sym", id), sym, 2'b10);
      check($sformatf("sb%0d_idle_last", id), ol, 0);
      check($sformatf("sb%0d_no_bubble", id), mid[id], 0);
      idle_cnt[id]++;
    end
    if (v && rdy) begin
      for (int i = 0; i < N; i++) begin
        e.sym  = msg[W-1-2*i -: 2];
        e.last = (i == N - 1);
        q[id].push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (sb_en) begin
      sb_step(0, 0, sym0, ov0, ol0, val0, rdy0, msg0);
      sb_step(1, 2, sym2, ov2, ol2, val2, rdy2, msg2);
    end
  end

  // ---------------- directed tables ----------------
  typedef struct {
    logic v; logic [W-1:0] m; logic rdy; logic [1:0] sym; logic ov; logic ol;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic v, input logic [W-1:0] m, input logic rdy,
                     input logic [1:0] sym, input logic ov, input logic ol);
    vec_t t;
    t.v = v; t.m = m; t.rdy = rdy; t.sym = sym; t.ov = ov; t.ol = ol;
    vq.push_back(t);
  endtask

  logic [1:0] g_sym [11];
  logic       g_val [11];
  logic       g_last[11];

  initial begin
    // single 0x5D, then idle
    add(1, 8'h5D, 1, 2'b01, 1, 0);
    add(0, 8'h00, 1, 2'b01, 1, 0);
    add(0, 8'h00, 1, 2'b11, 1, 0);
    add(0, 8'h00, 1, 2'b01, 1, 1);
    add(0, 8'h00, 1, 2'b10, 0, 0);
    add(0, 8'h00, 1, 2'b10, 0, 0);
    // 0x5D then 0xA4 back to back; 0xFF/0x3C offered while stalled
    add(1, 8'h5D, 1, 2'b01, 1, 0);
    add(1, 8'hA4, 1, 2'b01, 1, 0);
    add(1, 8'hFF, 0, 2'b11, 1, 0);
    add(1, 8'hFF, 0, 2'b01, 1, 1);
    add(1, 8'h3C, 0, 2'b10, 1, 0);
    add(1, 8'h3C, 1, 2'b10, 1, 0);
    add(0, 8'h00, 0, 2'b01, 1, 0);
    add(0, 8'h00, 0, 2'b00, 1, 1);
    add(0, 8'h00, 0, 2'b00, 1, 0);
    add(0, 8'h00, 1, 2'b11, 1, 0);
    add(0, 8'h00, 1, 2'b11, 1, 0);
    add(0, 8'h00, 1, 2'b00, 1, 1);
    add(0, 8'h00, 1, 2'b10, 0, 0);

    g_sym  = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b10, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10};
    g_val  = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0};
    g_last = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};

    // reset and idle
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sym", sym0, 2'b10);
    check("rst_val", ov0, 0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("idle%0d_sym0", c), sym0, 2'b10);
      check($sformatf("idle%0d_val0", c), ov0, 0);
      check($sformatf("idle%0d_last0", c), ol0, 0);
      check($sformatf("idle%0d_rdy0", c), rdy0, 1);
      check($sformatf("idle%0d_sym2", c), sym2, 2'b10);
      check($sformatf("idle%0d_rdy2", c), rdy2, 1);
    end

    foreach (vq[i]) begin
      val0 = vq[i].v;
      msg0 = vq[i].m;
      check($sformatf("vec%0d_rdy", i), rdy0, vq[i].rdy);
      @(posedge clk); #1;
      check($sformatf("vec%0d_sym", i), sym0, vq[i].sym);
      check($sformatf("vec%0d_val", i), ov0, vq[i].ov);
      check($sformatf("vec%0d_last", i), ol0, vq[i].ol);
    end
    val0 = 1'b0;

    // GAP_SYMS=2: two 0x44 messages separated by two idle symbols
    for (int c = 0; c < 11; c++) begin
      val2 = (c < 2);
      msg2 = (c < 2) ? 8'h44 : 8'h00;
      if (c < 2) check($sformatf("gap%0d_rdy", c), rdy2, 1);
      @(posedge clk); #1;
      check($sformatf("gap%0d_sym", c), sym2, g_sym[c]);
      check($sformatf("gap%0d_val", c), ov2, g_val[c]);
      check($sformatf("gap%0d_last", c), ol2, g_last[c]);
    end
    val2 = 1'b0;

    // reset at the second dibit of 0xFF with 0x00 pending
    val0 = 1'b1; msg0 = 8'hFF;
    @(posedge clk); #1;
    msg0 = 8'h00;
    check("rstmid_rdy_before", rdy0, 1);
    @(posedge clk); #1;
    check("rstmid_second_dibit", sym0, 2'b11);
    check("rstmid_pbuf_full", rdy0, 0);
    val0 = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rstmid_sym", sym0, 2'b10);
    check("rstmid_val", ov0, 0);
    check("rstmid_rdy", rdy0, 1);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check($sformatf("rstmid_quiet%0d", c), ov0, 0);
    end

    // randomized traffic on both instances against the scoreboard
    idle_cnt[0] = 100; idle_cnt[1] = 100;
    mid[0] = 1'b0;     mid[1] = 1'b0;
    sb_en = 1'b1;
    for (int c = 0; c < 600; c++) begin
      val0 = ($urandom_range(0, 99) < 70);
      msg0 = W'($urandom);
      val2 = ($urandom_range(0, 99) < 50);
      msg2 = W'($urandom);
      @(posedge clk); #1;
    end
    val0 = 1'b0;
    val2 = 1'b0;
    begin : drain
      bit done;
      done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
        @(posedge clk); #1;
        done = (q[0].size() == 0) && (q[1].size() == 0) && !ov0 && !ov2;
      end
      @(negedge clk);
      check("drain_complete", done, 1);
    end
    sb_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
